mem_stage_ctrl: RTL and testbench

Sequences data-memory accesses for the MEM stage of the 5-stage RISC-V pipeline.
- Converts the single-cycle mem_read/mem_write intent from EX/MEM into a req/ready handshake with a variable-latency data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Suppresses write-back into MEM_WB when an access is aborted.
- Returns load data ready for MEM_WB capture on the cycle the stage releases.

---
 rtl/mem_ctrl_pkg.sv | 7 +
 rtl/mem_timeout_ctr.sv | 17 +
 rtl/mem_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding, access-size codes and timeout default for mem_stage_ctrl
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int unsigned TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: 8-bit access-wait counter with clear, enable and expired flag
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == 8'(LIMIT - 1);
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory sequencer (req/ready handshake, stall, wb_kill).
// Define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles with a bus_err pulse.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              lh,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [1:0]        dmem_size,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              wb_kill,
  output logic              misalign,
  output logic              bus_err
);
  state_e state_q, state_d;
  logic req_q, req_d, we_q, we_d, mis_q, mis_d, berr_q, berr_d, kill_q, kill_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, load_q, load_d;
  logic op, bad, go, timeout;
  assign op = (mem_read | mem_write) & ~flush;
  assign bad = op & ((lh & addr[0]) | (~lh & mem_read & (addr[1:0] != 2'b00)) |
                     (mem_write & (addr[1:0] != 2'b00)));
  assign go = (state_q == IDLE) & op & ~bad;
`ifdef MEM_TIMEOUT_EN
  logic expired;
  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (go),
    .en      ((state_q == ACCESS) & ~dmem_ready),
    .expired (expired)
  );
  assign timeout = (state_q == ACCESS) & ~dmem_ready & expired;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    we_d = we_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    load_d = load_q;
    mis_d = 1'b0;
    berr_d = 1'b0;
    kill_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bad) begin
          state_d = DONE;
          mis_d = 1'b1;
          kill_d = 1'b1;
        end else if (go) begin
          state_d = ACCESS;
          req_d = 1'b1;
          we_d = mem_write;
          size_d = (lh & ~mem_write) ? SIZE_HALF : SIZE_WORD;
          addr_d = addr;
          wdata_d = wdata;
        end
      end
      ACCESS: begin
        // a ready arriving on the limit cycle wins over the timeout
        if (dmem_ready | timeout) begin
          state_d = DONE;
          req_d = 1'b0;
          berr_d = timeout;
          kill_d = timeout;
          load_d = timeout ? 32'd0 : we_q ? load_q : dmem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= '0;
      load_q <= '0;
      mis_q <= 1'b0;
      berr_q <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      load_q <= load_d;
      mis_q <= mis_d;
      berr_q <= berr_d;
      kill_q <= kill_d;
    end
  assign stall = ((state_q == IDLE) & op) | (state_q == ACCESS);
  assign dmem_req = req_q;
  assign dmem_we = we_q;
  assign dmem_size = size_q;
  assign dmem_addr = addr_q;
  assign dmem_wdata = wdata_q;
  assign load_data = load_q;
  assign wb_kill = kill_q;
  assign misalign = mis_q;
  assign bus_err = berr_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
  localparam int TO = 4;
  logic clk = 0, reset = 1, mem_read = 0, mem_write = 0, lh = 0, flush = 0, dmem_ready = 0;
  logic [31:0] addr = 0, wdata = 0, dmem_rdata = 0;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic dmem_req, dmem_we, stall, wb_kill, misalign, bus_err;
  logic [1:0] dmem_size;
  int tests = 0, fails = 0, stall_cnt = 0;
  typedef struct {int stl; logic [31:0] ld; logic kill; logic mis; logic berr;} resp_t;
  typedef struct {logic we; logic [1:0] sz; logic [31:0] a; logic [31:0] wd;} req_t;
  resp_t eq[$];
  req_t rq[$];
  logic [31:0] model_ld = 0;
  bit mon_en = 0, prev_stall = 0, prev_req = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .lh(lh),
    .flush(flush), .addr(addr), .wdata(wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_size(dmem_size), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall(stall), .load_data(load_data),
    .wb_kill(wb_kill), .misalign(misalign), .bus_err(bus_err)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    tests++;
    fails++;
    $display("FAIL %s: unexpected DUT activity", n);
  endtask

  task automatic scramble();
    mem_read = 1'($urandom);
    mem_write = 1'($urandom);
    lh = 1'($urandom);
    flush = 1'($urandom);
    addr = $urandom;
    wdata = $urandom;
  endtask

  // one MEM-stage op: IDLE cycle, then w wait cycles and a ready cycle, then DONE
  task automatic do_op(input logic rd, input logic wr, input logic h, input logic fl,
                       input logic [31:0] a, input logic [31:0] wd, input int w,
                       input logic [31:0] rdat, input bit to);
    bit op, bad, to_eff;
    req_t r;
    resp_t e;
    op = (rd || wr) && !fl;
    bad = op && ((h && rd && !wr) ? a[0] : (a[1:0] != 2'b00));
    to_eff = op && !bad && to;
    mem_read = rd; mem_write = wr; lh = h; flush = fl; addr = a; wdata = wd;
    dmem_ready = 1'($urandom);
    dmem_rdata = $urandom;
    if (op && !bad) begin
      r.we = wr; r.sz = (h && !wr) ? 2'b01 : 2'b10; r.a = a; r.wd = wd;
      rq.push_back(r);
      if (to_eff) model_ld = 0;
      else if (!wr) model_ld = rdat;
    end
    e.stl = !op ? 0 : bad ? 1 : to_eff ? 1 + TO : w + 2;
    e.ld = model_ld; e.kill = bad || to_eff; e.mis = bad; e.berr = to_eff;
    if (op) eq.push_back(e);
    @(posedge clk); #1;
    if (op) begin
      if (!bad) begin
        for (int i = 0; i < (to_eff ? TO : w); i++) begin
          scramble(); dmem_ready = 0; @(posedge clk); #1;
        end
        if (!to_eff) begin
          scramble(); dmem_ready = 1; dmem_rdata = rdat; @(posedge clk); #1;
        end
      end
      scramble(); dmem_ready = 1'($urandom); @(posedge clk); #1;
    end
    dmem_ready = 0;
  endtask

  always @(negedge clk) begin : mon
    resp_t e;
    if (mon_en) begin
      if (stall) stall_cnt++;
      if (prev_stall && !stall) begin
        if (eq.size() == 0) fail("spurious_done");
        else begin
          e = eq.pop_front();
          chk("stall_cycles", stall_cnt, e.stl);
          chk("load_data", load_data, e.ld);
          chk("wb_kill", wb_kill, e.kill);
          chk("misalign", misalign, e.mis);
          chk("bus_err", bus_err, e.berr);
        end
        stall_cnt = 0;
      end else begin
        chk("misalign_quiet", misalign, 0);
        chk("wb_kill_quiet", wb_kill, 0);
        chk("bus_err_quiet", bus_err, 0);
      end
      if (dmem_req) begin
        if (rq.size() == 0) fail("spurious_req");
        else begin
          chk("req_addr", dmem_addr, rq[0].a);
          chk("req_we", dmem_we, rq[0].we);
          chk("req_size", dmem_size, rq[0].sz);
          chk("req_wdata", dmem_wdata, rq[0].wd);
        end
      end
      if (prev_req && !dmem_req && rq.size() != 0) void'(rq.pop_front());
      prev_stall = stall;
      prev_req = dmem_req;
    end
  end

  initial begin
    #12;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_stall", stall, 0);
    chk("rst_size", dmem_size, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_load", load_data, 0);
    chk("rst_flags", {misalign, wb_kill, bus_err}, 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    mon_en = 1;
    do_op(1, 0, 0, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
    do_op(0, 1, 0, 0, 32'h204, 32'h12345678, 3, 32'h0, 0);
    do_op(1, 0, 1, 0, 32'h101, 32'h0, 0, 32'h0, 0);
    do_op(1, 0, 0, 0, 32'h10, 32'h0, 0, 32'hA5A50001, 0);
    do_op(1, 0, 0, 0, 32'h14, 32'h0, 0, 32'hA5A50002, 0);
    do_op(1, 0, 0, 1, 32'h20, 32'h0, 0, 32'h0, 0);
`ifdef MEM_TIMEOUT_EN
    do_op(1, 0, 0, 0, 32'h40, 32'h0, 0, 32'h0, 1);
`endif
    for (int n = 0; n < 300; n++) begin
      int k;
      bit to;
      logic [31:0] a;
      k = $urandom_range(3);
      to = 0;
`ifdef MEM_TIMEOUT_EN
      to = ($urandom_range(7) == 0);
`endif
      a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      do_op(k == 1, k == 2, 1'($urandom), $urandom_range(5) == 0, a, $urandom,
            $urandom_range(4), $urandom, to);
    end
    mem_read = 0; mem_write = 0; flush = 0;
    @(posedge clk); #1;
    chk("resp_q_empty", eq.size(), 0);
    chk("req_q_empty", rq.size(), 0);
    mon_en = 0;
    mem_read = 1; lh = 0; addr = 32'h80; dmem_ready = 0;
    @(posedge clk); #1;
    chk("pre_rst_req", dmem_req, 1);
    chk("pre_rst_stall", stall, 1);
    #2 reset = 1; mem_read = 0;
    #1;
    chk("async_rst_req", dmem_req, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_addr", dmem_addr, 0);
    @(negedge clk); reset = 0; mem_read = 1; flush = 1; addr = 32'h100;
    #1 chk("flush_stall", stall, 0);
    @(posedge clk); #1;
    chk("flush_req", dmem_req, 0);
    chk("flush_stall_after", stall, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
